// File: rtl/alu_arbiter.sv
// Two-requester front end for a multi-cycle ALU: round-robin grant, one op in flight,
// fixed-latency result capture and a one-cycle response strobe back to the grantee.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       alu_on,
    output logic [2:0] alu_in_sel,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [6:0] alu_out_sel,
    input  logic [7:0] alu_out,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [1:0] state
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_WAIT = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;
    localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       grantee_q, grantee_d;
    logic [7:0] num1_q, num1_d, num2_q, num2_d;
    logic [6:0] sel_q, sel_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    logic       grant0, grant1, accept;
    logic [2:0] acc_op;
    logic [7:0] acc_a, acc_b;

    // last_q high means requester 1 won the previous grant, so requester 0 wins a tie.
    assign grant0     = req0_valid && (!req1_valid || last_q);
    assign grant1     = req1_valid && !grant0;
    assign req0_ready = (state_q == S_IDLE) && grant0;
    assign req1_ready = (state_q == S_IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign acc_op     = grant1 ? req1_op : req0_op;
    assign acc_a      = grant1 ? req1_a  : req0_a;
    assign acc_b      = grant1 ? req1_b  : req0_b;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grantee_d  = grantee_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        sel_d      = sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    last_d    = grant1;
                    grantee_d = grant1;
                    if (acc_op == OP_ILLEGAL) begin
                        // Illegal ops bypass the ALU entirely and answer straight away.
                        state_d    = S_DONE;
                        rsp_data_d = 8'h00;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        num1_d  = acc_a;
                        num2_d  = acc_b;
                        sel_d   = 7'b1000000 >> acc_op;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_INIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_DONE;
                    rsp_data_d = alu_out;
                    rsp_err_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            last_q     <= 1'b1;
            grantee_q  <= 1'b0;
            num1_q     <= 8'h00;
            num2_q     <= 8'h00;
            sel_q      <= 7'd0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grantee_q  <= grantee_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            sel_q      <= sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_on      = (state_q != S_IDLE);
    assign alu_in_sel  = (state_q == S_IDLE) ? 3'b001 :
                         (state_q == S_LOAD) ? 3'b010 : 3'b100;
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = sel_q;
    assign rsp0_valid  = (state_q == S_DONE) && !grantee_q;
    assign rsp1_valid  = (state_q == S_DONE) && grantee_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign state       = state_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Drives two arbiters (ALU_LAT=2 and ALU_LAT=5) with shared stimulus and checks
// each against a transaction-level model of grant, latency and response rules.
module tb_alu_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v0, v1;
    logic [2:0] o0, o1;
    logic [7:0] a0, b0, a1, b1;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic       on   [2];
    logic       rv0  [2];
    logic       rv1  [2];
    logic       rerr [2];
    logic [2:0] insel[2];
    logic [7:0] n1   [2];
    logic [7:0] n2   [2];
    logic [7:0] aout [2];
    logic [7:0] rdata[2];
    logic [6:0] osel [2];
    logic [1:0] st   [2];

    int checks = 0;
    int errors = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 5;
    endfunction

    function automatic logic [7:0] ref_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return {a[6:0], b[7]};
            3'd6: return ~a;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [2:0] sel2op(input logic [6:0] sel);
        logic [6:0] one;
        for (int i = 0; i < 7; i++) begin
            one = 7'b1000000 >> i;
            if (sel == one) return 3'(i);
        end
        return 3'd7;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_arbiter #(.ALU_LAT(gi == 0 ? 2 : 5)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0), .req0_op(o0), .req0_a(a0), .req0_b(b0),
            .req1_valid(v1), .req1_op(o1), .req1_a(a1), .req1_b(b1),
            .req0_ready(rdy0[gi]), .req1_ready(rdy1[gi]),
            .alu_on(on[gi]), .alu_in_sel(insel[gi]),
            .alu_num1(n1[gi]), .alu_num2(n2[gi]), .alu_out_sel(osel[gi]),
            .alu_out(aout[gi]),
            .rsp0_valid(rv0[gi]), .rsp1_valid(rv1[gi]),
            .rsp_data(rdata[gi]), .rsp_err(rerr[gi]), .state(st[gi])
        );
        // External ALU: combinational function of what the arbiter presents.
        assign aout[gi] = ref_f(sel2op(osel[gi]), n1[gi], n2[gi]);
    end

    // Reference model: cycle numbers of acceptance, derived occupancy window.
    int         cyc;
    int         free_at [2];
    int         acc_e   [2];
    bit         legal_m [2];
    bit         gnt_m   [2];
    bit         last_m  [2];
    logic [7:0] m_n1    [2];
    logic [7:0] m_n2    [2];
    logic [6:0] m_sel   [2];
    logic [7:0] m_pdata [2];
    logic [7:0] m_data  [2];
    bit         m_perr  [2];
    bit         m_err   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state(input int k);
        int off;
        if (cyc >= free_at[k]) return 0;
        if (!legal_m[k]) return 3;
        off = cyc - acc_e[k];
        if (off == 0) return 1;
        if (off <= lat(k)) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            free_at[k] = 0; acc_e[k] = 0; legal_m[k] = 0; gnt_m[k] = 0; last_m[k] = 1;
            m_n1[k] = 0; m_n2[k] = 0; m_sel[k] = 0;
            m_pdata[k] = 0; m_data[k] = 0; m_perr[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic check_outputs();
        int es;
        for (int k = 0; k < 2; k++) begin
            es = exp_state(k);
            if (es == 3) begin
                m_data[k] = m_pdata[k];
                m_err[k]  = m_perr[k];
                $display("TXN lat=%0d req%0d data=%02h err=%0d", lat(k), gnt_m[k], m_data[k], m_err[k]);
            end
            chk("state",    32'(st[k]),    32'(es));
            chk("alu_on",   32'(on[k]),    32'(es != 0));
            chk("in_sel",   32'(insel[k]), (es == 0) ? 32'd1 : (es == 1) ? 32'd2 : 32'd4);
            chk("num1",     32'(n1[k]),    32'(m_n1[k]));
            chk("num2",     32'(n2[k]),    32'(m_n2[k]));
            chk("out_sel",  32'(osel[k]),  32'(m_sel[k]));
            chk("rsp0",     32'(rv0[k]),   32'(es == 3 && !gnt_m[k]));
            chk("rsp1",     32'(rv1[k]),   32'(es == 3 && gnt_m[k]));
            chk("rsp_data", 32'(rdata[k]), 32'(m_data[k]));
            chk("rsp_err",  32'(rerr[k]),  32'(m_err[k]));
        end
    endtask

    task automatic do_cycle(input logic iv0, input logic [2:0] io0, input logic [7:0] ia0, input logic [7:0] ib0,
                            input logic iv1, input logic [2:0] io1, input logic [7:0] ia1, input logic [7:0] ib1);
        bit acc [2];
        bit g1  [2];
        bit g0;
        logic [2:0] op;
        logic [7:0] a, b;
        v0 = iv0; o0 = io0; a0 = ia0; b0 = ib0;
        v1 = iv1; o1 = io1; a1 = ia1; b1 = ib1;
        #1;
        for (int k = 0; k < 2; k++) begin
            g0 = iv0 && (!iv1 || last_m[k]);
            g1[k] = iv1 && !g0;
            acc[k] = (cyc >= free_at[k]) && (g0 || g1[k]);
            chk("ready0", 32'(rdy0[k]), 32'((cyc >= free_at[k]) && g0));
            chk("ready1", 32'(rdy1[k]), 32'((cyc >= free_at[k]) && g1[k]));
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                op = g1[k] ? io1 : io0;
                a  = g1[k] ? ia1 : ia0;
                b  = g1[k] ? ib1 : ib0;
                acc_e[k] = cyc; gnt_m[k] = g1[k]; last_m[k] = g1[k];
                legal_m[k] = (op != 3'd7);
                if (legal_m[k]) begin
                    m_n1[k] = a; m_n2[k] = b; m_sel[k] = 7'b1000000 >> op;
                    m_pdata[k] = ref_f(op, a, b); m_perr[k] = 0;
                    free_at[k] = cyc + lat(k) + 2;
                end else begin
                    m_pdata[k] = 8'h00; m_perr[k] = 1;
                    free_at[k] = cyc + 1;
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted mid-cycle: state must drop before any clock edge.
    task automatic do_reset();
        v0 = 0; v1 = 0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_state", 32'(st[k]), 32'd0);
            chk("rst_rsp",   32'(rv0[k] | rv1[k]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; v0 = 0; v1 = 0; o0 = 0; o1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        cyc = 0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Single add, then operand changed to FF while in flight.
        do_cycle(1, 3'd0, 8'h57, 8'h1A, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) do_cycle(1, 3'd0, 8'hFF, 8'h1A, 0, 0, 0, 0);
        idle_cycles(8);

        // Continuous tie: grants must alternate.
        for (int i = 0; i < 24; i++)
            do_cycle(1, 3'd3, 8'($urandom), 8'($urandom), 1, 3'd5, 8'($urandom), 8'($urandom));
        idle_cycles(8);

        // Illegal op from requester 1.
        do_cycle(0, 0, 0, 0, 1, 3'd7, 8'h12, 8'h34);
        idle_cycles(8);

        // Reset while both instances are in WAIT, then a tie must go to req0.
        do_cycle(1, 3'd1, 8'h40, 8'h01, 0, 0, 0, 0);
        idle_cycles(2);
        do_reset();
        do_cycle(1, 3'd2, 8'hF0, 8'h3C, 1, 3'd4, 8'h0F, 8'hAA);
        idle_cycles(8);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            else do_cycle(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        idle_cycles(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
